// File: rtl/fifo_read_gray_ctrl_pkg.sv
// Shared definitions for the fifo_cdcc read-side controller: Gray-code helpers
// and the default synchronizer depth, also used by the write-side controller.
package fifo_read_gray_ctrl_pkg;

    localparam int DEFAULT_SYNC_STAGES = 2;

    // Helpers work on a 64-bit container; callers zero-extend and truncate.
    function automatic logic [63:0] bin2gray(input logic [63:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [63:0] gray2bin(input logic [63:0] g);
        logic [63:0] b;
        b[63] = g[63];
        for (int i = 62; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_read_gray_ctrl_if.sv
// Output word stream of the read-side controller.
// Handshake: a word transfers on a clock edge where o_valid & i_ready; once raised,
// o_valid and o_data hold until that transfer, and o_valid never depends on i_ready.
interface fifo_read_gray_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;
    logic                  i_ready;

    modport master (output o_data, output o_valid, input i_ready);
    modport slave  (input o_data, input o_valid, output i_ready);
endinterface

// File: rtl/fifo_read_gray_ctrl_gray_ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing clock domains.
module fifo_read_gray_ctrl_gray_ptr_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] r_sync [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i - 1];
            end
        end
    end

    assign o_q = r_sync[STAGES - 1];

endmodule

// File: rtl/fifo_read_gray_ctrl.sv
// Read-side pointer controller of the fifo_cdcc dual-clock FIFO: drains the BRAM
// through a 2-entry skid buffer and exports its Gray tail pointer to the writer.
module fifo_read_gray_ctrl
    import fifo_read_gray_ctrl_pkg::*;
#(
    parameter int INT_FIFO_PTR_BITS_CNT = 32,
    parameter int DATA_WIDTH            = 32,
    parameter int SYNC_STAGES           = DEFAULT_SYNC_STAGES
) (
    input  logic                             rd_clk,
    input  logic                             rd_rst_n,
    output logic                             read_en,
    output logic [INT_FIFO_PTR_BITS_CNT-1:0] o_rd_intptr,
    input  logic [DATA_WIDTH-1:0]            i_rd_data,
    output logic [INT_FIFO_PTR_BITS_CNT:0]   o_rd_grayptr,
    input  logic [INT_FIFO_PTR_BITS_CNT:0]   i_wr_grayptr,
    fifo_read_gray_ctrl_if.master            o_axis,
    output logic                             o_empty,
    output logic [INT_FIFO_PTR_BITS_CNT:0]   o_rd_level
);

    localparam int PTR_W = INT_FIFO_PTR_BITS_CNT + 1;

    logic [PTR_W-1:0]      r_tail;
    logic [PTR_W-1:0]      r_rd_gray;
    logic [PTR_W-1:0]      r_level;
    logic                  r_inflight;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_skid_valid;
    logic [DATA_WIDTH-1:0] r_skid_data;

    logic [PTR_W-1:0]      w_wr_gray_s;
    logic [PTR_W-1:0]      w_wr_bin;
    logic [PTR_W-1:0]      w_tail_gray;
    logic                  w_empty;
    logic                  w_pop;
    logic [1:0]            w_occ;
    logic [1:0]            w_occ_after_pop;
    logic                  w_read_en;

    fifo_read_gray_ctrl_gray_ptr_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_wr_ptr_sync (
        .clk   (rd_clk),
        .rst_n (rd_rst_n),
        .i_d   (i_wr_grayptr),
        .o_q   (w_wr_gray_s)
    );

    assign w_tail_gray = PTR_W'(bin2gray(64'(r_tail)));
    assign w_wr_bin    = PTR_W'(gray2bin(64'(w_wr_gray_s)));
    assign w_empty     = (w_tail_gray == w_wr_gray_s);

    // Reads in flight count against buffer space so the skid register never overflows.
    assign w_pop           = r_out_valid & o_axis.i_ready;
    assign w_occ           = {1'b0, r_out_valid} + {1'b0, r_skid_valid} + {1'b0, r_inflight};
    assign w_occ_after_pop = w_occ - {1'b0, w_pop};
    assign w_read_en       = ~w_empty & (w_occ_after_pop < 2'd2);

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_tail       <= '0;
            r_rd_gray    <= '0;
            r_level      <= '0;
            r_inflight   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else begin
            r_rd_gray  <= w_tail_gray;
            r_level    <= w_wr_bin - r_tail;
            r_inflight <= w_read_en;
            if (w_read_en) begin
                r_tail <= r_tail + PTR_W'(1);
            end

            // Skid word moves up on a pop; the arriving BRAM word lands behind it.
            if (w_pop) begin
                if (r_skid_valid) begin
                    r_out_data   <= r_skid_data;
                    r_skid_valid <= r_inflight;
                    if (r_inflight) begin
                        r_skid_data <= i_rd_data;
                    end
                end else begin
                    r_out_valid <= r_inflight;
                    if (r_inflight) begin
                        r_out_data <= i_rd_data;
                    end
                end
            end else if (r_inflight) begin
                if (!r_out_valid) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= i_rd_data;
                end else begin
                    r_skid_valid <= 1'b1;
                    r_skid_data  <= i_rd_data;
                end
            end
        end
    end

    assign read_en        = w_read_en;
    assign o_rd_intptr    = r_tail[INT_FIFO_PTR_BITS_CNT-1:0];
    assign o_rd_grayptr   = r_rd_gray;
    assign o_rd_level     = r_level;
    assign o_empty        = w_empty;
    assign o_axis.o_valid = r_out_valid;
    assign o_axis.o_data  = r_out_data;

endmodule

// File: tb/tb_fifo_read_gray_ctrl.sv
// Directed bench for fifo_read_gray_ctrl with N=4, 8-bit data, 2 sync stages
// and a 1-cycle-latency BRAM model.
module tb_fifo_read_gray_ctrl;

    localparam int N  = 4;
    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          read_en;
    logic [N-1:0]  rd_intptr;
    logic [DW-1:0] rd_data;
    logic [N:0]    rd_grayptr;
    logic [N:0]    wr_grayptr;
    logic          empty;
    logic [N:0]    rd_level;

    logic [DW-1:0] mem [16];
    logic [DW-1:0] exp_q [$];

    int checks = 0;
    int errors = 0;

    fifo_read_gray_ctrl_if #(.DATA_WIDTH(DW)) axis ();

    fifo_read_gray_ctrl #(
        .INT_FIFO_PTR_BITS_CNT (N),
        .DATA_WIDTH            (DW),
        .SYNC_STAGES           (2)
    ) dut (
        .rd_clk       (clk),
        .rd_rst_n     (rst_n),
        .read_en      (read_en),
        .o_rd_intptr  (rd_intptr),
        .i_rd_data    (rd_data),
        .o_rd_grayptr (rd_grayptr),
        .i_wr_grayptr (wr_grayptr),
        .o_axis       (axis),
        .o_empty      (empty),
        .o_rd_level   (rd_level)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: data appears the cycle after read_en
    always @(posedge clk) begin
        if (read_en) rd_data <= mem[rd_intptr];
    end

    function automatic logic [N:0] g(input int v);
        logic [N:0] b;
        b = (N+1)'(v);
        return b ^ (b >> 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        wr_grayptr = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin : main
        int rcnt, vcnt, first_v, raddr, got, gaps, wp, rp, hold_pend;
        logic [DW-1:0] vdata, held, expd;
        logic [N:0] prev_g;
        logic wrapped;

        rst_n         = 1'b0;
        wr_grayptr    = '0;
        axis.i_ready  = 1'b1;
        for (int k = 0; k < 16; k++) mem[k] = '0;

        // 1: reset held, writer pointer toggling
        for (int k = 0; k < 4; k++) begin
            wr_grayptr = g(k + 1);
            step();
            chk("rst_valid", 32'(axis.o_valid), 32'd0);
            chk("rst_read_en", 32'(read_en), 32'd0);
            chk("rst_empty", 32'(empty), 32'd1);
            chk("rst_grayptr", 32'(rd_grayptr), 32'd0);
            chk("rst_level", 32'(rd_level), 32'd0);
        end
        chk("rst_intptr", 32'(rd_intptr), 32'd0);
        chk("rst_data", 32'(axis.o_data), 32'd0);
        wr_grayptr = '0;
        step();
        rst_n = 1'b1;
        step();
        step();

        // 2: single word, latency
        mem[0] = 8'hA5;
        axis.i_ready = 1'b1;
        wr_grayptr = 5'b00001;
        rcnt = 0; vcnt = 0; first_v = -1; raddr = -1; vdata = '0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (read_en) begin
                rcnt++;
                raddr = int'(rd_intptr);
            end
            if (axis.o_valid) begin
                vcnt++;
                if (first_v < 0) first_v = i;
                vdata = axis.o_data;
            end
        end
        chk("one_read_en_cnt", 32'(rcnt), 32'd1);
        chk("one_read_addr", 32'(raddr), 32'd0);
        chk("one_valid_cnt", 32'(vcnt), 32'd1);
        chk("one_latency", 32'(first_v), 32'd4);
        chk("one_data", 32'(vdata), 32'hA5);
        chk("one_grayptr", 32'(rd_grayptr), 32'h01);
        chk("one_empty", 32'(empty), 32'd1);
        chk("one_level", 32'(rd_level), 32'd0);

        // 3: full FIFO with consumer stalled, then drain
        do_reset();
        for (int k = 0; k < 16; k++) mem[k] = 8'(8'h40 + k);
        axis.i_ready = 1'b0;
        wr_grayptr = g(16);
        rcnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (read_en) rcnt++;
            if (axis.o_valid) chk("stall_data", 32'(axis.o_data), 32'h40);
        end
        chk("stall_read_en_cnt", 32'(rcnt), 32'd2);
        chk("stall_valid", 32'(axis.o_valid), 32'd1);
        chk("stall_level", 32'(rd_level), 32'd14);
        chk("stall_empty", 32'(empty), 32'd0);
        axis.i_ready = 1'b1;
        got = 0; gaps = 0;
        for (int i = 0; i < 40 && got < 16; i++) begin
            if (axis.o_valid) begin
                chk("drain_data", 32'(axis.o_data), 32'(8'h40 + got));
                got++;
            end else if (got > 0) begin
                gaps++;
            end
            step();
        end
        chk("drain_count", 32'(got), 32'd16);
        chk("drain_gaps", 32'(gaps), 32'd0);
        step();
        chk("drain_valid_low", 32'(axis.o_valid), 32'd0);
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_level", 32'(rd_level), 32'd0);

        // 4: trickling writer across pointer wrap
        do_reset();
        exp_q.delete();
        axis.i_ready = 1'b1;
        wp = 0; rp = 0; prev_g = '0; wrapped = 1'b0;
        for (int c = 0; c < 300 && rp < 41; c++) begin
            if (axis.o_valid) begin
                if (exp_q.size() > 0) expd = exp_q.pop_front();
                else expd = 'x;
                chk("wrap_data", 32'(axis.o_data), 32'(expd));
                rp++;
            end
            if (rd_grayptr !== prev_g) begin
                chk("wrap_gray_1bit", 32'($countones(rd_grayptr ^ prev_g)), 32'd1);
                if (prev_g == g(31) && rd_grayptr == g(0)) wrapped = 1'b1;
                prev_g = rd_grayptr;
            end
            if ((c % 2) == 0 && wp < 41) begin
                mem[wp % 16] = 8'(wp * 7 + 3);
                exp_q.push_back(8'(wp * 7 + 3));
                wp++;
                wr_grayptr = g(wp);
            end
            step();
        end
        chk("wrap_words", 32'(rp), 32'd41);
        chk("wrap_seen", 32'(wrapped), 32'd1);
        chk("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

        // 5: random back-pressure
        do_reset();
        exp_q.delete();
        for (int k = 0; k < 16; k++) begin
            mem[k] = 8'(k * 13 + 5);
            exp_q.push_back(8'(k * 13 + 5));
        end
        wr_grayptr = g(16);
        got = 0; hold_pend = 0; held = '0;
        for (int i = 0; i < 300 && got < 16; i++) begin
            if (hold_pend != 0) begin
                chk("bp_hold_valid", 32'(axis.o_valid), 32'd1);
                chk("bp_hold_data", 32'(axis.o_data), 32'(held));
            end
            axis.i_ready = 1'($urandom_range(0, 1));
            hold_pend = 0;
            if (axis.o_valid && axis.i_ready) begin
                expd = exp_q.pop_front();
                chk("bp_data", 32'(axis.o_data), 32'(expd));
                got++;
            end else if (axis.o_valid) begin
                hold_pend = 1;
                held = axis.o_data;
            end
            step();
        end
        axis.i_ready = 1'b1;
        step();
        step();
        step();
        chk("bp_count", 32'(got), 32'd16);
        chk("bp_no_extra", 32'(axis.o_valid), 32'd0);

        // 6: asynchronous reset mid-stream
        do_reset();
        for (int k = 0; k < 16; k++) mem[k] = 8'(k);
        axis.i_ready = 1'b0;
        wr_grayptr = g(16);
        for (int i = 0; i < 8; i++) step();
        axis.i_ready = 1'b1;
        #1;
        chk("mid_valid_pre", 32'(axis.o_valid), 32'd1);
        chk("mid_read_en_pre", 32'(read_en), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_valid", 32'(axis.o_valid), 32'd0);
        chk("mid_read_en", 32'(read_en), 32'd0);
        chk("mid_intptr", 32'(rd_intptr), 32'd0);
        chk("mid_grayptr", 32'(rd_grayptr), 32'd0);
        chk("mid_level", 32'(rd_level), 32'd0);
        chk("mid_empty", 32'(empty), 32'd1);
        wr_grayptr = '0;
        step();
        step();
        rst_n = 1'b1;
        rcnt = 0; vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (read_en) rcnt++;
            if (axis.o_valid) vcnt++;
        end
        chk("post_read_en_cnt", 32'(rcnt), 32'd0);
        chk("post_valid_cnt", 32'(vcnt), 32'd0);
        chk("post_empty", 32'(empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
